pll_lock_seq: RTL and testbench

Lock-qualified reset sequencer placed between the PLL and the two clock-domain counters. It synchronises the PLL LOCKED flag into the 100 MHz domain. It holds the counters' reset until lock has been continuously stable for a programmable time, and forces a reset hold whenever lock drops. It also keeps a saturating count of lock-loss events for display.

---
 rtl/pll_lock_seq.sv | 153 +++++++++++++++
 tb/tb_pll_lock_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_seq.sv
// Lock-qualified reset sequencer: synchronises PLL LOCKED, qualifies it over a
// stable window and holds the downstream counters in reset otherwise.
// Optional lock-loss counter enabled by defining PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_seq #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOSS_W        = 8
) (
  input  logic              clk_100MHz_i,
  input  logic              rst_i,
  input  logic              lock_i,
  input  logic              en_i,
  input  logic              clr_i,
  output logic              cnt_rst_o,
  output logic              cnt_en_o,
  output logic              lock_sync_o,
  output logic [1:0]        state_o,
  output logic [LOSS_W-1:0] loss_cnt_o
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2,
    ST_LOST      = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_lock_sync;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_cnt_rst;
  logic              r_cnt_en;
  logic              w_cnt_rst_nxt;
  logic              w_cnt_en_nxt;

  // Two-flop synchroniser for the asynchronous LOCKED flag
  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_sync1     <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_sync1     <= lock_i;
      r_lock_sync <= r_sync1;
    end
  end

  // State and qualification/hold counters
  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_state    <= ST_WAIT_LOCK;
      r_stab_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Next-state logic; counters are cleared on entry to their state
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_sync) begin
          w_state_nxt = ST_STABLE;
          w_stab_nxt  = '0;
        end
      end
      ST_STABLE: begin
        if (!r_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stab_nxt = r_stab_cnt + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!r_lock_sync || clr_i) begin
          w_state_nxt = ST_LOST;
          w_hold_nxt  = '0;
        end
      end
      ST_LOST: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Outputs decoded from the next state so they change with the state register
  always_comb begin
    w_cnt_rst_nxt = 1'b1;
    w_cnt_en_nxt  = 1'b0;
    if (w_state_nxt == ST_RUN) begin
      w_cnt_rst_nxt = 1'b0;
      w_cnt_en_nxt  = en_i;
    end
  end

  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_cnt_rst <= 1'b1;
      r_cnt_en  <= 1'b0;
    end else begin
      r_cnt_rst <= w_cnt_rst_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
    end
  end

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [LOSS_W-1:0] r_loss_cnt;
  logic              w_loss_evt;

  // A lock drop in RUN counts as a loss even when clr_i coincides
  assign w_loss_evt = (r_state == ST_RUN) && !r_lock_sync;

  always_ff @(posedge clk_100MHz_i) begin
    if (rst_i) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
    end
  end

  assign loss_cnt_o = r_loss_cnt;
`else
  assign loss_cnt_o = '0;
`endif

  assign cnt_rst_o   = r_cnt_rst;
  assign cnt_en_o    = r_cnt_en;
  assign lock_sync_o = r_lock_sync;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: directed scenarios plus random lock,
// clear, enable and reset traffic against a timestamp-based reference model.
module tb_pll_lock_seq;

  localparam int S    = 8;
  localparam int H    = 4;
  localparam int LW   = 2;
  localparam int LMAX = (1 << LW) - 1;

  logic          clk;
  logic          rst_i;
  logic          lock_i;
  logic          en_i;
  logic          clr_i;
  logic          cnt_rst_o;
  logic          cnt_en_o;
  logic          lock_sync_o;
  logic [1:0]    state_o;
  logic [LW-1:0] loss_cnt_o;
  logic [6:0]    act;

  int checks = 0;
  int errors = 0;

  pll_lock_seq #(
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .LOSS_W       (LW)
  ) dut (
    .clk_100MHz_i(clk),
    .rst_i       (rst_i),
    .lock_i      (lock_i),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .cnt_rst_o   (cnt_rst_o),
    .cnt_en_o    (cnt_en_o),
    .lock_sync_o (lock_sync_o),
    .state_o     (state_o),
    .loss_cnt_o  (loss_cnt_o)
  );

  assign act = {cnt_rst_o, cnt_en_o, lock_sync_o, state_o, loss_cnt_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode plus edge timestamps for the qualification and hold windows
  int   m_edge = 0;
  int   m_mode = 0;
  int   m_since = 0;
  int   m_hold_end = 0;
  int   m_loss = 0;
  logic m_s1 = 1'b0;
  logic m_ls = 1'b0;
  logic m_rst_o = 1'b1;
  logic m_en_o = 1'b0;

  task automatic model_edge();
    logic ls_seen;
    m_edge++;
    if (rst_i) begin
      m_s1 = 1'b0; m_ls = 1'b0; m_mode = 0; m_loss = 0;
    end else begin
      ls_seen = m_ls;
      m_ls    = m_s1;
      m_s1    = lock_i;
      case (m_mode)
        0: if (ls_seen) begin m_mode = 1; m_since = m_edge; end
        1: if (!ls_seen) m_mode = 0;
           else if (m_edge - m_since == S) m_mode = 2;
        2: if (!ls_seen || clr_i) begin
             m_mode = 3;
             m_hold_end = m_edge + H;
             if (!ls_seen && m_loss < LMAX) m_loss++;
           end
        default: if (m_edge == m_hold_end) m_mode = 0;
      endcase
    end
    m_rst_o = (m_mode != 2);
    m_en_o  = en_i && (m_mode == 2) && !rst_i;
  endtask

  function automatic int exp_loss();
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_rst_o, m_en_o, m_ls, 2'(m_mode), LW'(exp_loss())};
  endfunction

  task automatic step(input logic r, input logic l, input logic e, input logic c);
    rst_i = r; lock_i = l; en_i = e; clr_i = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_run(input logic e, output int n);
    n = 0;
    while (state_o != 2'd2 && n < 60) begin
      step(1'b0, 1'b1, e, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset();
    int ones = 0;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (act !== 7'b1000000) begin
        errors++; $display("FAIL reset_vals act=%b exp=%b", act, 7'b1000000);
      end
    end
    do begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      if (cnt_rst_o) ones++;
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL powerup_model cyc=%0d act=%b exp=%b", n, act, exp_vec());
      end
    end while (cnt_rst_o && n < 60);
    checks++;
    if (ones !== 2 + S || state_o !== 2'd2) begin
      errors++; $display("FAIL powerup_release rst_cycles=%0d state=%0d exp %0d/2", ones, state_o, 2 + S);
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    int run_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, (i < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (state_o == 2'd2 || !cnt_rst_o) run_seen++;
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL glitch_model i=%0d act=%b exp=%b", i, act, exp_vec());
      end
    end
    checks++;
    if (run_seen !== 0) begin
      errors++; $display("FAIL glitch_no_run run_cycles=%0d exp 0", run_seen);
    end
    do begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL glitch_requal cyc=%0d act=%b exp=%b", n, act, exp_vec());
      end
    end while (state_o != 2'd2 && n < 60);
    checks++;
    if (n !== S + 3) begin
      errors++; $display("FAIL glitch_latency steps=%0d exp %0d", n, S + 3);
    end
  endtask

  task automatic test_loss();
    int n;
    int lost = 0;
    int seq[$];
    logic [1:0] prev;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    go_run(1'b0, n);
    prev = state_o;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      if (n > 0) step(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      if (state_o == 2'd3) lost++;
      if (state_o != prev) seq.push_back(int'(state_o));
      prev = state_o;
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL loss_model cyc=%0d act=%b exp=%b", n, act, exp_vec());
      end
    end while (!(state_o == 2'd2 && seq.size() > 0) && n < 60);
    checks++;
    if (lost !== H || seq.size() != 4 || seq[0] != 3 || seq[1] != 0 || seq[2] != 1 || seq[3] != 2) begin
      errors++; $display("FAIL loss_sequence lost_cycles=%0d transitions=%0d exp %0d lost, 3-0-1-2", lost, seq.size(), H);
    end
    checks++;
    if (int'(loss_cnt_o) !== exp_loss() || exp_loss() > 1) begin
      errors++; $display("FAIL loss_count act=%0d exp=%0d", loss_cnt_o, exp_loss());
    end
  endtask

  task automatic test_saturation();
    int n;
    int want;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    go_run(1'b0, n);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      go_run(1'b0, n);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      want = (i + 1 < LMAX) ? i + 1 : LMAX;
`else
      want = 0;
`endif
      checks++;
      if (int'(loss_cnt_o) !== want || state_o !== 2'd2 || act !== exp_vec()) begin
        errors++; $display("FAIL saturation ev=%0d loss=%0d exp=%0d state=%0d", i + 1, loss_cnt_o, want, state_o);
      end
    end
  endtask

  task automatic test_clear();
    int n;
    int want;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    go_run(1'b0, n);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (state_o !== 2'd3 || loss_cnt_o !== '0 || act !== exp_vec()) begin
      errors++; $display("FAIL clear_in_run state=%0d loss=%0d exp 3/0", state_o, loss_cnt_o);
    end
    go_run(1'b0, n);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    want = 1;
`else
    want = 0;
`endif
    checks++;
    if (state_o !== 2'd3 || int'(loss_cnt_o) !== want || act !== exp_vec()) begin
      errors++; $display("FAIL clear_with_drop state=%0d loss=%0d exp 3/%0d", state_o, loss_cnt_o, want);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (state_o !== 2'd0 || act !== exp_vec()) begin
        errors++; $display("FAIL clear_in_wait state=%0d act=%b exp=%b", state_o, act, exp_vec());
      end
    end
  endtask

  task automatic test_enable_reset();
    int n;
    logic [2:0] pat;
    pat = 3'b101;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    go_run(1'b0, n);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, pat[i], 1'b0);
      checks++;
      if (cnt_en_o !== pat[i] || act !== exp_vec()) begin
        errors++; $display("FAIL enable_gate i=%0d en_o=%b exp=%b", i, cnt_en_o, pat[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (act !== 7'b1000000) begin
      errors++; $display("FAIL reset_mid_run act=%b exp=%b", act, 7'b1000000);
    end
  endtask

  task automatic test_random();
    logic l = 1'b1;
    logic e = 1'b0;
    logic r;
    logic c;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) l = ~l;
      if ($urandom_range(9, 0) == 0) e = ~e;
      c = ($urandom_range(24, 0) == 0);
      r = ($urandom_range(299, 0) == 0);
      step(r, l, e, c);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d act=%b exp=%b", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; lock_i = 1'b1; en_i = 1'b0; clr_i = 1'b0;
    test_reset();
    test_glitch();
    test_loss();
    test_saturation();
    test_clear();
    test_enable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
